lvds_tx_train: RTL
==================

Name: lvds_tx_train

Overview:
- Transmit-side link trainer for the LVDS word path. Sits between the payload source and the serializer word input.
- After enable, sends a fixed training pattern so the far-end receiver can bitslip-align its word boundary. Waits for the far-end lock indication, holds the pattern a little longer, then passes payload words with a valid/ready handshake.
- Drops back to training if lock is lost.

Parameters:
- DATA_WIDTH, 10, serializer word width.
- MIN_TRAIN, 16, minimum pattern words sent before lock is honoured (1..255).
- LOCK_HOLD, 8, extra pattern words sent after lock is accepted (1..255).
- TIMEOUT, 4096, pattern words without lock before a timeout pulse and restart (2..65535).

Ports:
- clk  input  1  word clock.
- rst_n  input  1  asynchronous active-low reset.
- train_en  input  1  level; 1 = run link, 0 = force IDLE.
- pattern  input  DATA_WIDTH  training word; static while train_en=1.
- idle_word  input  DATA_WIDTH  word sent when no payload is available.
- rx_locked  input  1  far-end alignment done; asynchronous; synchronised internally.
- s_data  input  DATA_WIDTH  payload word.
- s_valid  input  1  payload valid.
- s_ready  output  1  payload accepted when s_valid and s_ready are both 1.
- tx_data  output  DATA_WIDTH  registered word to the serializer.
- tx_training  output  1  registered; 1 in TRAIN and HOLD.
- link_up  output  1  registered; 1 in LINK.
- train_timeout  output  1  one-cycle pulse on each timeout.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, tx_data=0, tx_training=0, link_up=0, train_timeout=0, all counters 0, sync flops 0.
- Lock synchroniser: rx_locked passes through 2 flops to give lock_s. Latency is 2 cycles.
- s_ready: combinational, equal to (state==LINK). It never depends on s_valid.
- tx_data: registered, so each word appears 1 cycle after the state/input that selects it.
- Priority each cycle: train_en=0 > timeout > lock transitions.
- IDLE (00):
  - tx_data <= idle_word.
  - train_cnt, hold_cnt and tmo_cnt are cleared.
  - Go to TRAIN when train_en=1.
- TRAIN (01):
  - tx_data <= pattern.
  - train_cnt increments and saturates at MIN_TRAIN.
  - tmo_cnt increments.
  - If lock_s=1 and train_cnt==MIN_TRAIN: go to HOLD and clear hold_cnt.
  - Else if tmo_cnt==TIMEOUT-1: pulse train_timeout for 1 cycle, clear train_cnt and tmo_cnt, stay in TRAIN.
  - A lock_s seen before MIN_TRAIN is reached is ignored until the count saturates.
- HOLD (10):
  - tx_data <= pattern.
  - hold_cnt increments; at hold_cnt==LOCK_HOLD-1 go to LINK.
  - lock_s=0 returns to TRAIN with all counters cleared.
  - No timeout check in HOLD.
- LINK (11):
  - tx_data <= s_data if s_valid=1, else idle_word.
  - lock_s=0 returns to TRAIN with counters cleared. The beat accepted in that same cycle is still emitted. s_ready drops the next cycle.
- train_en=0 in any state: go to IDLE next cycle and tx_data <= idle_word. An s_valid beat in the same LINK cycle is accepted and emitted.
- Outputs tx_training and link_up are registered with the state, so they are valid in the same cycle the state's first word appears on tx_data.
- Counters: 8-bit train_cnt and hold_cnt, 16-bit tmo_cnt. No wrap is possible within the allowed parameter ranges.
- Reset mid-operation: immediately returns all outputs to their reset values, regardless of state.

Test Plan:
- Reset, then train_en=1 with rx_locked=0. Required: pattern=10'h2F0 from cycle 2 onward, tx_training=1, s_ready=0, no timeout before word 4096.
- rx_locked=1 held from the start with MIN_TRAIN=16, LOCK_HOLD=8. Required: exactly 24 pattern words, then link_up=1 and s_ready=1. s_data 10'h001..10'h004 with s_valid=1 appear on tx_data one cycle after acceptance, in order.
- In LINK, s_valid toggling 1,0,1 with data A,B. Required: tx_data=A, idle_word, B. s_ready stays 1 throughout.
- rx_locked never asserts with TIMEOUT=100. Required: train_timeout pulses at pattern words 100, 200 and 300. tx_data stays pattern throughout.
- In LINK, rx_locked drops while s_valid=1 with data 10'h155. Required: 10'h155 is emitted; 2 sync cycles later tx_training=1 and pattern resumes; a minimum of 16+8 words passes before LINK is reached again.
- Mid-HOLD, train_en=0. Required: next tx_data=idle_word and outputs return to IDLE values. Assert rst_n=0 mid-LINK: tx_data=0 immediately.

Source files
------------

// File: rtl/lvds_tx_train.sv
// Transmit link trainer: sends pattern until far-end lock (+hold), then passes payload words.
// tx_data is one cycle behind selection; s_ready is combinational and high only in LINK.
module lvds_tx_train #(
  parameter int DATA_WIDTH = 10,
  parameter int MIN_TRAIN  = 16,
  parameter int LOCK_HOLD  = 8,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  train_en,
  input  logic [DATA_WIDTH-1:0] pattern,
  input  logic [DATA_WIDTH-1:0] idle_word,
  input  logic                  rx_locked,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_training,
  output logic                  link_up,
  output logic                  train_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRAIN = 2'b01,
    HOLD  = 2'b10,
    LINK  = 2'b11
  } state_t;

  localparam logic [7:0]  MIN_C     = 8'(MIN_TRAIN);
  localparam logic [7:0]  HOLD_LAST = 8'(LOCK_HOLD - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

  state_t                  state, state_nxt;
  logic                    lock_meta, lock_s;
  logic [7:0]              train_cnt, train_cnt_nxt, train_inc;
  logic [7:0]              hold_cnt, hold_cnt_nxt;
  logic [15:0]             tmo_cnt, tmo_cnt_nxt;
  logic [DATA_WIDTH-1:0]   tx_data_nxt;
  logic                    timeout_nxt;
  logic                    training_nxt, link_up_nxt;

  assign s_ready   = (state == LINK);
  // train_cnt counts pattern words already sent; lock is honoured on the MIN_TRAIN-th word
  assign train_inc = (train_cnt == MIN_C) ? train_cnt : train_cnt + 8'd1;

  always_comb begin
    state_nxt     = state;
    train_cnt_nxt = train_cnt;
    hold_cnt_nxt  = hold_cnt;
    tmo_cnt_nxt   = tmo_cnt;
    tx_data_nxt   = idle_word;
    timeout_nxt   = 1'b0;
    training_nxt  = train_en && ((state == TRAIN) || (state == HOLD));
    link_up_nxt   = train_en && (state == LINK);

    if (!train_en) begin
      state_nxt     = IDLE;
      train_cnt_nxt = 8'd0;
      hold_cnt_nxt  = 8'd0;
      tmo_cnt_nxt   = 16'd0;
      if ((state == LINK) && s_valid) tx_data_nxt = s_data;
    end else begin
      case (state)
        IDLE: begin
          state_nxt     = TRAIN;
          train_cnt_nxt = 8'd0;
          hold_cnt_nxt  = 8'd0;
          tmo_cnt_nxt   = 16'd0;
        end
        TRAIN: begin
          tx_data_nxt   = pattern;
          train_cnt_nxt = train_inc;
          tmo_cnt_nxt   = tmo_cnt + 16'd1;
          if (lock_s && (train_inc == MIN_C)) begin
            state_nxt    = HOLD;
            hold_cnt_nxt = 8'd0;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_nxt   = 1'b1;
            train_cnt_nxt = 8'd0;
            tmo_cnt_nxt   = 16'd0;
          end
        end
        HOLD: begin
          tx_data_nxt = pattern;
          if (!lock_s) begin
            state_nxt     = TRAIN;
            train_cnt_nxt = 8'd0;
            hold_cnt_nxt  = 8'd0;
            tmo_cnt_nxt   = 16'd0;
          end else if (hold_cnt == HOLD_LAST) begin
            state_nxt = LINK;
          end else begin
            hold_cnt_nxt = hold_cnt + 8'd1;
          end
        end
        LINK: begin
          tx_data_nxt = s_valid ? s_data : idle_word;
          if (!lock_s) begin
            state_nxt     = TRAIN;
            train_cnt_nxt = 8'd0;
            hold_cnt_nxt  = 8'd0;
            tmo_cnt_nxt   = 16'd0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      lock_meta     <= 1'b0;
      lock_s        <= 1'b0;
      train_cnt     <= 8'd0;
      hold_cnt      <= 8'd0;
      tmo_cnt       <= 16'd0;
      tx_data       <= '0;
      tx_training   <= 1'b0;
      link_up       <= 1'b0;
      train_timeout <= 1'b0;
    end else begin
      state         <= state_nxt;
      lock_meta     <= rx_locked;
      lock_s        <= lock_meta;
      train_cnt     <= train_cnt_nxt;
      hold_cnt      <= hold_cnt_nxt;
      tmo_cnt       <= tmo_cnt_nxt;
      tx_data       <= tx_data_nxt;
      tx_training   <= training_nxt;
      link_up       <= link_up_nxt;
      train_timeout <= timeout_nxt;
    end
  end

endmodule
